// File: rtl/ifu_fetch_buf_ctl_if.sv
// Fetch-buffer bus: F2 fetch block in, 2-halfword aligner window and retire pulses out.
// The master side is the fetch/aligner environment; the buffer itself is the slave.
interface ifu_fetch_buf_ctl_if;
    logic        ifc_fetch_req_f2;
    logic        ic_hit_f2;
    logic [31:1] ifc_fetch_addr_f2;
    logic [63:0] ic_rd_data_f2;
    logic [1:0]  aln_consume_hw;
    logic [1:0]  fb_out_vld;
    logic [31:0] fb_out_data;
    logic [31:1] fb_out_pc;
    logic        ifu_fb_consume1;
    logic        ifu_fb_consume2;

    modport master (
        output ifc_fetch_req_f2, ic_hit_f2, ifc_fetch_addr_f2, ic_rd_data_f2, aln_consume_hw,
        input  fb_out_vld, fb_out_data, fb_out_pc, ifu_fb_consume1, ifu_fb_consume2
    );

    modport slave (
        input  ifc_fetch_req_f2, ic_hit_f2, ifc_fetch_addr_f2, ic_rd_data_f2, aln_consume_hw,
        output fb_out_vld, fb_out_data, fb_out_pc, ifu_fb_consume1, ifu_fb_consume2
    );
endinterface

// File: rtl/ifu_fetch_buf_ctl.sv
// Fetch buffer at the F2/aligner boundary: FIFO of fetch blocks presenting a 2-halfword window.
// Optional per-halfword parity protection is enabled by defining RV_FB_PARITY_EN.
module ifu_fetch_buf_ctl #(
    parameter int DEPTH      = 4,
    parameter int HW_PER_BLK = 4
) (
    input  logic               clk,
    input  logic               rst,
    ifu_fetch_buf_ctl_if.slave fb_if,
    input  logic               exu_flush_final,
    input  logic               dec_takenbr,
    output logic [2:0]         fb_count,
    output logic               fb_full,
    output logic               fb_err
`ifdef RV_FB_PARITY_EN
    ,
    output logic               fb_parity_err
`endif
);

    localparam int PW = $clog2(DEPTH);
    typedef logic [PW-1:0] ptr_t;

    logic [63:0]      data_q      [DEPTH];
    logic [31:3]      blk_addr_q  [DEPTH];
    logic [1:0]       start_off_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    ptr_t             wr_ptr_q;
    ptr_t             rd_ptr_q;
    logic [1:0]       hw_ptr_q;
    logic [2:0]       count_q;
    logic             err_q;

    ptr_t        head;
    ptr_t        nxt;
    ptr_t        nxt2;
    logic        head_vld;
    logic        hw1_vld;
    logic [1:0]  hw1_idx;
    logic [15:0] hw0;
    logic [15:0] hw1;

    logic        ext_flush;
    logic        flush;
    logic [1:0]  avail;
    logic        cons_bad;
    logic [1:0]  n_eff;
    logic [2:0]  new_ptr;
    logic [2:0]  rem;
    logic [2:0]  nxt_sum;
    logic        retire1;
    logic        retire2;
    logic [1:0]  ret_cnt;
    logic [2:0]  occ;
    logic        wr_req;
    logic        wr_drop;
    logic        wr_ok;
    logic [2:0]  count_d;
    ptr_t        rd_ptr_d;
    logic [1:0]  hw_ptr_d;

    assign head      = rd_ptr_q;
    assign nxt       = rd_ptr_q + ptr_t'(1);
    assign nxt2      = rd_ptr_q + ptr_t'(2);
    assign ext_flush = exu_flush_final | dec_takenbr;

    // hw1 spills into the next entry once the head pointer sits on its last halfword
    always_comb begin
        hw1_idx  = hw_ptr_q + 2'd1;
        head_vld = vld_q[head];
        hw0      = data_q[head][{hw_ptr_q, 4'b0000} +: 16];
        if (hw_ptr_q != 2'd3) begin
            hw1     = data_q[head][{hw1_idx, 4'b0000} +: 16];
            hw1_vld = head_vld;
        end else begin
            hw1     = data_q[nxt][{start_off_q[nxt], 4'b0000} +: 16];
            hw1_vld = head_vld & vld_q[nxt];
        end
    end

`ifdef RV_FB_PARITY_EN
    logic [3:0] par_q [DEPTH];
    logic       hw0_par;
    logic       hw1_par;
    logic       par_err;

    always_comb begin
        hw0_par = par_q[head][hw_ptr_q];
        hw1_par = (hw_ptr_q != 2'd3) ? par_q[head][hw1_idx] : par_q[nxt][start_off_q[nxt]];
        par_err = ~ext_flush & (fb_if.aln_consume_hw != 2'd0) &
                  ((head_vld & ((^hw0) ^ hw0_par)) | (hw1_vld & ((^hw1) ^ hw1_par)));
    end

    assign flush         = ext_flush | par_err;
    assign fb_parity_err = par_err;
`else
    assign flush = ext_flush;
`endif

    // Retire bookkeeping: a consume may walk off the head and, at most, off one more entry
    always_comb begin
        avail    = {1'b0, head_vld} + {1'b0, hw1_vld};
        cons_bad = ~flush & ((fb_if.aln_consume_hw == 2'd3) | (fb_if.aln_consume_hw > avail));
        n_eff    = (flush | cons_bad) ? 2'd0 : fb_if.aln_consume_hw;
        new_ptr  = {1'b0, hw_ptr_q} + {1'b0, n_eff};
        rem      = new_ptr - 3'(HW_PER_BLK);
        nxt_sum  = {1'b0, start_off_q[nxt]} + rem;
        retire1  = new_ptr >= 3'(HW_PER_BLK);
        retire2  = retire1 & (nxt_sum >= 3'(HW_PER_BLK));
        ret_cnt  = retire2 ? 2'd2 : (retire1 ? 2'd1 : 2'd0);
        occ      = count_q - {1'b0, ret_cnt};
        wr_req   = fb_if.ifc_fetch_req_f2 & fb_if.ic_hit_f2 & ~flush;
        wr_drop  = wr_req & (occ == 3'(DEPTH));
        wr_ok    = wr_req & ~wr_drop;
        count_d  = occ + {2'b00, wr_ok};
        rd_ptr_d = rd_ptr_q + ptr_t'(ret_cnt);
        if (wr_ok && (occ == 3'd0)) begin
            hw_ptr_d = fb_if.ifc_fetch_addr_f2[2:1];
        end else if (retire2) begin
            hw_ptr_d = start_off_q[nxt2];
        end else if (retire1) begin
            hw_ptr_d = nxt_sum[1:0];
        end else begin
            hw_ptr_d = new_ptr[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            hw_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            err_q    <= 1'b0;
        end else if (flush) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            hw_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (cons_bad | wr_drop) begin
                err_q <= 1'b1;
            end
            if (retire1) begin
                vld_q[head] <= 1'b0;
            end
            if (retire2) begin
                vld_q[nxt] <= 1'b0;
            end
            if (wr_ok) begin
                vld_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q        <= wr_ptr_q + ptr_t'(1);
            end
            rd_ptr_q <= rd_ptr_d;
            hw_ptr_q <= hw_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; validity lives entirely in vld_q
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            data_q[wr_ptr_q]      <= fb_if.ic_rd_data_f2;
            blk_addr_q[wr_ptr_q]  <= fb_if.ifc_fetch_addr_f2[31:3];
            start_off_q[wr_ptr_q] <= fb_if.ifc_fetch_addr_f2[2:1];
`ifdef RV_FB_PARITY_EN
            par_q[wr_ptr_q] <= {^fb_if.ic_rd_data_f2[63:48], ^fb_if.ic_rd_data_f2[47:32],
                                ^fb_if.ic_rd_data_f2[31:16], ^fb_if.ic_rd_data_f2[15:0]};
`endif
        end
    end

    assign fb_if.fb_out_vld      = {hw1_vld, head_vld};
    assign fb_if.fb_out_data     = {(hw1_vld ? hw1 : 16'h0000), (head_vld ? hw0 : 16'h0000)};
    assign fb_if.fb_out_pc       = head_vld ? {blk_addr_q[head], hw_ptr_q} : 31'd0;
    assign fb_if.ifu_fb_consume1 = retire1 & ~retire2;
    assign fb_if.ifu_fb_consume2 = retire2;
    assign fb_count              = count_q;
    assign fb_full               = (count_q == 3'(DEPTH));
    assign fb_err                = err_q;

endmodule

// File: tb/tb_ifu_fetch_buf_ctl.sv
// Self-checking bench for ifu_fetch_buf_ctl: directed scenarios plus random traffic
// compared against a halfword-stream model of the buffer.
module tb_ifu_fetch_buf_ctl;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       exu_flush_final = 1'b0;
    logic       dec_takenbr = 1'b0;
    logic [2:0] fb_count;
    logic       fb_full;
    logic       fb_err;
`ifdef RV_FB_PARITY_EN
    logic       fb_parity_err;
`endif

    ifu_fetch_buf_ctl_if fb_if ();

    ifu_fetch_buf_ctl #(.DEPTH(DEPTH), .HW_PER_BLK(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .fb_if           (fb_if.slave),
        .exu_flush_final (exu_flush_final),
        .dec_takenbr     (dec_takenbr),
        .fb_count        (fb_count),
        .fb_full         (fb_full),
        .fb_err          (fb_err)
`ifdef RV_FB_PARITY_EN
        ,
        .fb_parity_err   (fb_parity_err)
`endif
    );

    always #5 clk = ~clk;

    // The model sees the buffer as a stream of halfwords tagged with their fetch block
    typedef struct {
        logic [15:0] hw;
        logic [30:0] pc;
        int          blk;
    } hw_t;

    hw_t  model_q[$];
    int   blk_seq;
    logic model_err;
    logic model_force_flush;
    int   pass_count;
    int   check_count;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_count++;
        if (got === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int modelBlocks();
        int b = 0;
        for (int i = 0; i < model_q.size(); i++) begin
            if (i == 0 || model_q[i].blk != model_q[i-1].blk) b++;
        end
        return b;
    endfunction

    function automatic int modelAvail();
        return (model_q.size() > 2) ? 2 : model_q.size();
    endfunction

    task automatic resetDut();
        @(posedge clk); #1;
        rst = 1'b1;
        fb_if.ifc_fetch_req_f2  = 1'b0;
        fb_if.ic_hit_f2         = 1'b0;
        fb_if.ifc_fetch_addr_f2 = '0;
        fb_if.ic_rd_data_f2     = '0;
        fb_if.aln_consume_hw    = 2'd0;
        exu_flush_final         = 1'b0;
        dec_takenbr             = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_q.delete();
        model_err = 1'b0;
        model_force_flush = 1'b0;
        @(negedge clk);
    endtask

    // Drives one cycle, checks every output against the model, then advances the model.
    // Returns at the negedge with the inputs still applied.
    task automatic applyStimulus(input logic req, input logic hit, input logic [31:0] addr,
                                 input logic [63:0] data, input logic exu_f, input logic dec_f,
                                 input logic [1:0] n);
        int          blocks_before;
        int          blocks_after;
        int          sz;
        int          avail;
        int          ret;
        logic        do_flush;
        logic        bad;
        int          n_eff;
        logic [31:0] exp_data;
        logic [30:0] exp_pc;
        hw_t         e;

        @(posedge clk); #1;
        fb_if.ifc_fetch_req_f2  = req;
        fb_if.ic_hit_f2         = hit;
        fb_if.ifc_fetch_addr_f2 = addr[31:1];
        fb_if.ic_rd_data_f2     = data;
        fb_if.aln_consume_hw    = n;
        exu_flush_final         = exu_f;
        dec_takenbr             = dec_f;
        @(negedge clk);

        sz            = model_q.size();
        blocks_before = modelBlocks();
        avail         = modelAvail();
        exp_data      = {(sz >= 2) ? model_q[1].hw : 16'h0000, (sz >= 1) ? model_q[0].hw : 16'h0000};
        exp_pc        = (sz >= 1) ? model_q[0].pc : 31'd0;
        do_flush      = exu_f | dec_f | model_force_flush;
        bad           = !do_flush && (n == 2'd3 || int'(n) > avail);
        n_eff         = (do_flush || bad) ? 0 : int'(n);
        for (int i = 0; i < n_eff; i++) void'(model_q.pop_front());
        blocks_after  = modelBlocks();
        ret           = blocks_before - blocks_after;

        checkOutput("out_vld", 64'(fb_if.fb_out_vld), 64'({sz >= 2, sz >= 1}));
        checkOutput("out_data", 64'(fb_if.fb_out_data), 64'(exp_data));
        checkOutput("out_pc", 64'(fb_if.fb_out_pc), 64'(exp_pc));
        checkOutput("consume1", 64'(fb_if.ifu_fb_consume1), 64'(ret == 1));
        checkOutput("consume2", 64'(fb_if.ifu_fb_consume2), 64'(ret == 2));
        checkOutput("count", 64'(fb_count), 64'(blocks_before));
        checkOutput("full", 64'(fb_full), 64'(blocks_before == DEPTH));
        checkOutput("err", 64'(fb_err), 64'(model_err));
`ifdef RV_FB_PARITY_EN
        checkOutput("parity_err", 64'(fb_parity_err), 64'(model_force_flush));
`endif

        if (bad) model_err = 1'b1;
        if (do_flush) begin
            model_q.delete();
        end else if (req && hit) begin
            if (blocks_after == DEPTH) begin
                model_err = 1'b1;
            end else begin
                blk_seq++;
                for (int i = int'(addr[2:1]); i < 4; i++) begin
                    e.hw  = data[i*16 +: 16];
                    e.pc  = {addr[31:3], 2'(i)};
                    e.blk = blk_seq;
                    model_q.push_back(e);
                end
            end
        end
    endtask

    task automatic idleCycle(input logic [1:0] n);
        applyStimulus(1'b0, 1'b0, 32'h0, 64'h0, 1'b0, 1'b0, n);
    endtask

    task automatic writeBlock(input logic [31:0] addr, input logic [63:0] data);
        applyStimulus(1'b1, 1'b1, addr, data, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic randomCycles(input int cycles, input int illegal_pct);
        logic [1:0] n;
        for (int c = 0; c < cycles; c++) begin
            if ($urandom_range(99) < illegal_pct) n = 2'($urandom_range(3));
            else n = 2'($urandom_range(modelAvail()));
            applyStimulus(($urandom_range(3) != 0), ($urandom_range(3) != 0),
                          $urandom & 32'hFFFF_FFFE, {$urandom, $urandom},
                          ($urandom_range(19) == 0), ($urandom_range(29) == 0), n);
        end
    endtask

    initial begin
        pass_count  = 0;
        check_count = 0;
        blk_seq     = 0;
        model_err   = 1'b0;
        model_force_flush = 1'b0;

        // Reset and idle
        resetDut();
        idleCycle(2'd0);
        checkOutput("reset_count", 64'(fb_count), 64'd0);
        checkOutput("reset_vld", 64'(fb_if.fb_out_vld), 64'd0);
        checkOutput("reset_err", 64'(fb_err), 64'd0);

        // Single block consumed two halfwords at a time
        writeBlock(32'h1000, 64'h4444_3333_2222_1111);
        idleCycle(2'd2);
        checkOutput("blk_win0", 64'(fb_if.fb_out_data), 64'h2222_1111);
        checkOutput("blk_pc0", 64'(fb_if.fb_out_pc), 64'(32'h1000 >> 1));
        idleCycle(2'd2);
        checkOutput("blk_win1", 64'(fb_if.fb_out_data), 64'h4444_3333);
        checkOutput("blk_pc1", 64'(fb_if.fb_out_pc), 64'(32'h1004 >> 1));
        checkOutput("blk_c1", 64'(fb_if.ifu_fb_consume1), 64'd1);
        idleCycle(2'd0);
        checkOutput("blk_empty", 64'(fb_count), 64'd0);

        // Two blocks starting at offset 3 retire together
        writeBlock(32'h2006, {16'hAAAA, 48'h0});
        writeBlock(32'h3006, {16'hBBBB, 48'h0});
        idleCycle(2'd2);
        checkOutput("span_win", 64'(fb_if.fb_out_data), 64'hBBBB_AAAA);
        checkOutput("span_pc", 64'(fb_if.fb_out_pc), 64'(32'h2006 >> 1));
        checkOutput("span_c2", 64'(fb_if.ifu_fb_consume2), 64'd1);
        idleCycle(2'd0);
        checkOutput("span_empty", 64'(fb_count), 64'd0);

        // Overflow: fifth write is dropped and the error sticks
        resetDut();
        for (int i = 0; i < 4; i++) writeBlock(32'h5000 + 32'(i * 8), {$urandom, $urandom});
        writeBlock(32'h6000, 64'h1);
        checkOutput("ovf_full", 64'(fb_full), 64'd1);
        idleCycle(2'd0);
        checkOutput("ovf_err", 64'(fb_err), 64'd1);
        idleCycle(2'd0);
        checkOutput("ovf_sticky", 64'(fb_err), 64'd1);
        checkOutput("ovf_count", 64'(fb_count), 64'd4);

        // Flush coincident with write and consume
        resetDut();
        for (int i = 0; i < 3; i++) writeBlock(32'h7000 + 32'(i * 8), {$urandom, $urandom});
        applyStimulus(1'b1, 1'b1, 32'h8000, 64'h55, 1'b1, 1'b0, 2'd2);
        checkOutput("flush_noc1", 64'(fb_if.ifu_fb_consume1), 64'd0);
        checkOutput("flush_noc2", 64'(fb_if.ifu_fb_consume2), 64'd0);
        idleCycle(2'd0);
        checkOutput("flush_count", 64'(fb_count), 64'd0);
        checkOutput("flush_vld", 64'(fb_if.fb_out_vld), 64'd0);

`ifdef RV_FB_PARITY_EN
        // Corrupted stored halfword is caught on consume and flushes the buffer
        resetDut();
        writeBlock(32'h9000, 64'h0123_4567_89AB_CDEF);
        idleCycle(2'd0);
        dut.data_q[0][0] = ~dut.data_q[0][0];
        begin
            hw_t t;
            t = model_q[0];
            t.hw[0] = ~t.hw[0];
            model_q[0] = t;
        end
        model_force_flush = 1'b1;
        idleCycle(2'd1);
        checkOutput("par_pulse", 64'(fb_parity_err), 64'd1);
        model_force_flush = 1'b0;
        idleCycle(2'd0);
        checkOutput("par_count", 64'(fb_count), 64'd0);
`endif

        // Random traffic, legal consumes only, then with illegal consumes mixed in
        resetDut();
        randomCycles(400, 0);
        resetDut();
        randomCycles(200, 8);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/ifu_fetch_buf_ctl.md
Name: ifu_fetch_buf_ctl

Overview:
- Fetch buffer at the F2/aligner boundary: the receiving end of the fetch pipe.
- Captures each F2 fetch block that hits, queues it in a small FIFO, and presents a 2-halfword window to the aligner.
- Retires entries as the aligner consumes halfwords, reporting ifu_fb_consume1 / ifu_fb_consume2 back to fetch control so its fetch-buffer occupancy model stays balanced.

Parameters:
- DEPTH, 4, number of fetch-block entries (power of 2, ≥2).
- HW_PER_BLK, 4, halfwords per fetch block (64-bit block, address bits [2:1] select halfword).

Ports:
- clk  in  1  core clock, single domain.
- rst  in  1  synchronous, active-high reset.
- ifc_fetch_req_f2  in  1  F2 fetch valid.
- ic_hit_f2  in  1  F2 data valid (cache/ICCM hit).
- ifc_fetch_addr_f2  in  31  [31:1] F2 fetch address; [2:1] gives the start halfword.
- ic_rd_data_f2  in  64  F2 fetch block data.
- exu_flush_final  in  1  flush.
- dec_takenbr  in  1  decode taken branch, treated as flush.
- aln_consume_hw  in  2  halfwords consumed this cycle: 0, 1 or 2 (3 is illegal).
- fb_out_vld  out  2  bit i set = halfword i of the window is valid.
- fb_out_data  out  32  {hw1, hw0}.
- fb_out_pc  out  31  [31:1] address of hw0.
- ifu_fb_consume1  out  1  exactly one entry retired this cycle.
- ifu_fb_consume2  out  1  two entries retired this cycle.
- fb_count  out  3  occupied entries (0..DEPTH).
- fb_full  out  1  fb_count == DEPTH.
- fb_err  out  1  sticky protocol error.

Behaviour:
- State:
  - Per entry: data[63:0], blk_addr[31:3], start_off[1:0], vld.
  - Pointers: wr_ptr, rd_ptr (log2 DEPTH) and hw_ptr[1:0], the halfword offset in the head entry.
- Reset:
  - All vld = 0, pointers = 0, fb_err = 0.
  - All outputs 0 (fb_out_* gated by empty).
- Flush (exu_flush_final | dec_takenbr):
  - Next cycle all vld = 0 and pointers = 0.
  - A same-cycle F2 write is dropped; same-cycle consume is ignored (no consume1/2 pulse).
- Write:
  - Condition: ifc_fetch_req_f2 & ic_hit_f2 & ~flush.
  - Stores data, addr[31:3] and start_off = addr[2:1] at wr_ptr, sets vld, advances wr_ptr.
  - A write when full (net of same-cycle retire) is dropped and sets fb_err.
- Head offset: when an entry becomes head, hw_ptr = its start_off. An entry written into an empty buffer is visible to the aligner the following cycle; there is no bypass.
- Window:
  - hw0 = head halfword hw_ptr.
  - hw1 = head halfword hw_ptr+1 if hw_ptr<3, otherwise next entry's halfword start_off (valid only if that entry is valid).
  - fb_out_pc = {blk_addr, hw_ptr}.
- Consume (n = aln_consume_hw):
  - n greater than the number of valid window halfwords, or n=3, sets fb_err and is treated as 0.
  - new = hw_ptr + n (3-bit).
  - If new < 4: hw_ptr = new, no retire.
  - If new ≥ 4: head retires (rd_ptr+1).
    - Remainder r = new-4 is applied to the next entry: hw_ptr = next.start_off + r.
    - If next.start_off + r reaches 4, that entry also retires. This is possible only when next.start_off = 3 and r = 1; in that case rd_ptr+2 and the new head uses its own start_off.
- Consume pulses: one retire → ifu_fb_consume1; two → ifu_fb_consume2. They are combinational from the current state and aln_consume_hw, and mutually exclusive.
- Simultaneous write and retire in the same cycle is legal; fb_count updates by writes − retires.
- fb_err is cleared only by rst.

Optional Feature:
- Macro: RV_FB_PARITY_EN.
- When defined:
  - Each entry stores 4 even-parity bits, one per halfword, computed on write.
  - Window halfwords are checked on any cycle with nonzero consume.
  - A mismatch pulses output fb_parity_err (1 bit) for one cycle and forces a full flush of the buffer next cycle.
- When undefined: no parity storage, and the fb_parity_err port is absent.

Test Plan:
- Reset then idle → fb_count=0, fb_out_vld=00, consume1/2=0, fb_err=0.
- Write addr 0x1000, data 0x4444_3333_2222_1111; consume 2,2 → window {2222,1111} pc 0x1000, then {4444,3333} pc 0x1004; second cycle consume1=1, fb_count 1→0.
- Write addr 0x2006 (off 3, data hw3=0xAAAA), then addr 0x3006 (hw3=0xBBBB) → window {BBBB,AAAA} pc 0x2006; consume 2 → ifu_fb_consume2=1, fb_count 2→0.
- Fill 4 entries, write a 5th with no consume → dropped, fb_full=1, fb_err=1 sticky.
- 3 entries held, flush coincident with F2 write and consume 2 → next cycle fb_count=0, no consume pulse, write discarded.
- (RV_FB_PARITY_EN) force a stored data bit flip, consume 1 → fb_parity_err pulses one cycle, fb_count=0 next cycle.
